ad9833_freq_sequencer: RTL and testbench

- Upstream stage of the AD9833 serial driver.
- Accepts a frequency request in Hz plus a waveform select.
- Computes the 28-bit DDS tuning word with a sequential shift-subtract divider.
- Builds the control, FREQ0-LSB and FREQ0-MSB words, then runs a go/ack handshake with the driver followed by a guard interval before accepting the next request.

---
 rtl/ad9833_pkg.sv | 41 ++++
 rtl/ad9833_tw_divider.sv | 88 ++++++++
 rtl/ad9833_freq_sequencer.sv | 136 +++++++++++++
 tb/tb_ad9833_freq_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad9833_pkg.sv
// ad9833_pkg: shared types and constants for the AD9833 frequency sequencer.
//   state_e      - sequencer FSM states
//   CTRL_*       - AD9833 control word fields
//   MODE_*       - waveform mode bits in the control word
//   FREQ0_ADDR   - register address prefix for FREQ0 writes
//   WAVE_*       - wave_sel encodings
package ad9833_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIVIDE,
        LOAD,
        ISSUE,
        GUARD
    } state_e;

    localparam int TW_W = 28;

    localparam logic [15:0] CTRL_B28   = 16'h2000;
    localparam logic [15:0] CTRL_RESET = 16'h0100;
    localparam logic [15:0] MODE_SINE  = 16'h0000;
    localparam logic [15:0] MODE_TRI   = 16'h0002;
    localparam logic [15:0] MODE_SQR   = 16'h0028;

    localparam logic [1:0] FREQ0_ADDR = 2'b01;

    localparam logic [1:0] WAVE_SINE    = 2'd0;
    localparam logic [1:0] WAVE_TRI     = 2'd1;
    localparam logic [1:0] WAVE_SQR     = 2'd2;
    localparam logic [1:0] WAVE_ILLEGAL = 2'd3;

    function automatic logic [15:0] mode_bits(input logic [1:0] w);
        case (w)
            WAVE_TRI: return MODE_TRI;
            WAVE_SQR: return MODE_SQR;
            default:  return MODE_SINE;
        endcase
    endfunction

endpackage

// File: rtl/ad9833_tw_divider.sv
// ad9833_tw_divider: serial restoring divider, one quotient bit per clock.
//   clk, rst_n  - clock, async active-low reset
//   start_i     - load numerator and begin (one-cycle pulse)
//   num_i       - numerator, NUM_W bits
//   done_o      - one-cycle pulse when quot_o is final
//   quot_o      - low Q_W bits of num_i / DEN (held until the next start)
// Optional: AD9833_ROUND_NEAREST_EN adds one cycle that rounds the quotient
// to nearest (saturating) using the final remainder.
module ad9833_tw_divider #(
    parameter int NUM_W = 52,
    parameter int DEN   = 25000000,
    parameter int Q_W   = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    output logic             done_o,
    output logic [Q_W-1:0]   quot_o
);
    // Remainder is always < DEN, so one spare bit holds the shifted value.
    localparam int REM_W = $clog2(DEN) + 1;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [REM_W-1:0] DEN_V = REM_W'(DEN);

    logic [NUM_W-1:0] num_q;
    logic [REM_W-1:0] rem_q, rem_sh;
    logic [Q_W-1:0]   quot_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q, done_q, ge;

    assign rem_sh = {rem_q[REM_W-2:0], num_q[NUM_W-1]};
    assign ge     = (rem_sh >= DEN_V);

`ifdef AD9833_ROUND_NEAREST_EN
    logic rnd_q, rnd_up;
    assign rnd_up = ({rem_q, 1'b0} >= {1'b0, DEN_V});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
`ifdef AD9833_ROUND_NEAREST_EN
            rnd_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                num_q  <= num_i;
                rem_q  <= '0;
                quot_q <= '0;
                cnt_q  <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                num_q  <= {num_q[NUM_W-2:0], 1'b0};
                rem_q  <= ge ? (rem_sh - DEN_V) : rem_sh;
                // Upper quotient bits fall off the top; the caller bounds the input.
                quot_q <= {quot_q[Q_W-2:0], ge};
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_W - 1)) begin
                    run_q <= 1'b0;
`ifdef AD9833_ROUND_NEAREST_EN
                    rnd_q <= 1'b1;
`else
                    done_q <= 1'b1;
`endif
                end
            end
`ifdef AD9833_ROUND_NEAREST_EN
            else if (rnd_q) begin
                rnd_q  <= 1'b0;
                done_q <= 1'b1;
                if (rnd_up && !(&quot_q))
                    quot_q <= quot_q + 1'b1;
            end
`endif
        end
    end

    assign done_o = done_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/ad9833_freq_sequencer.sv
// ad9833_freq_sequencer: turns a (freq_hz, wave_sel) request into AD9833
// control / FREQ0 words and hands them to the serial driver via go/ack.
//   clk, rst_n        - clock, async active-low reset
//   req_valid/ready   - request handshake (ready only in IDLE)
//   freq_hz, wave_sel - request payload, captured on accept
//   busy, err         - not-idle flag; one-cycle reject pulse
//   go                - driver start, held until good_to_reset_go is seen
//   control, adreg0/1 - words for the driver, stable between loads
// Optional: AD9833_ROUND_NEAREST_EN rounds the tuning word to nearest
// (one extra divide cycle).
module ad9833_freq_sequencer
    import ad9833_pkg::*;
#(
    parameter int MCLK_HZ    = 25000000,
    parameter int GUARD_CLKS = 200,
    parameter int FREQ_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FREQ_W-1:0] freq_hz,
    input  logic [1:0]        wave_sel,
    output logic              busy,
    output logic              err,
    output logic              go,
    input  logic              good_to_reset_go,
    output logic [15:0]       control,
    output logic [15:0]       adreg0,
    output logic [15:0]       adreg1
);
    localparam int NUM_W = FREQ_W + TW_W;
    localparam int GC_W  = $clog2(GUARD_CLKS + 1);

    state_e            state_q, state_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [1:0]        wave_q, wave_d;
    logic [15:0]       ctrl_q, ctrl_d, a0_q, a0_d, a1_q, a1_d;
    logic [GC_W-1:0]   gcnt_q, gcnt_d;

    logic              reject, div_start, div_done;
    logic [TW_W-1:0]   tw;

    // Bounding freq below MCLK/2 also keeps the quotient within 28 bits.
    assign reject    = (64'(freq_q) >= 64'(MCLK_HZ / 2)) || (wave_q == WAVE_ILLEGAL);
    assign div_start = (state_q == CHECK) && !reject;

    ad9833_tw_divider #(
        .NUM_W (NUM_W),
        .DEN   (MCLK_HZ),
        .Q_W   (TW_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .num_i   ({freq_q, {TW_W{1'b0}}}),
        .done_o  (div_done),
        .quot_o  (tw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            freq_q  <= '0;
            wave_q  <= '0;
            ctrl_q  <= CTRL_B28 | CTRL_RESET;
            a0_q    <= {FREQ0_ADDR, 14'd0};
            a1_q    <= {FREQ0_ADDR, 14'd0};
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            wave_q  <= wave_d;
            ctrl_q  <= ctrl_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        wave_d  = wave_q;
        ctrl_d  = ctrl_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        gcnt_d  = gcnt_q;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    freq_d  = freq_hz;
                    wave_d  = wave_sel;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: if (div_done) state_d = LOAD;
            LOAD: begin
                a0_d    = {FREQ0_ADDR, tw[13:0]};
                a1_d    = {FREQ0_ADDR, tw[27:14]};
                ctrl_d  = CTRL_B28 | mode_bits(wave_q);
                state_d = ISSUE;
            end
            // go is high for every ISSUE cycle, so an ack seen here always
            // coincides with go==1.
            ISSUE: begin
                if (good_to_reset_go) begin
                    gcnt_d  = GC_W'(GUARD_CLKS - 1);
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (gcnt_q == '0) state_d = IDLE;
                else              gcnt_d  = gcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign go        = (state_q == ISSUE);
    assign control   = ctrl_q;
    assign adreg0    = a0_q;
    assign adreg1    = a1_q;

endmodule

// File: tb/tb_ad9833_freq_sequencer.sv
// tb_ad9833_freq_sequencer: directed + randomized bench for the AD9833
// frequency sequencer; expected words come from an arithmetic tuning-word model.
module tb_ad9833_freq_sequencer;
    localparam int MCLK = 25000000;
    localparam int G    = 200;
    localparam int FW   = 24;
`ifdef AD9833_ROUND_NEAREST_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int LAT = 1 + (FW + 28) + 1 + 1 + (RND ? 1 : 0);

    logic          clk, rst_n, req_valid, req_ready, busy, err, go, ack;
    logic [FW-1:0] freq_hz;
    logic [1:0]    wave_sel;
    logic [15:0]   control, adreg0, adreg1;

    int tests = 0;
    int fails = 0;
    logic [15:0] e_ctrl = 16'h2100, e_a0 = 16'h4000, e_a1 = 16'h4000;

    ad9833_freq_sequencer #(
        .MCLK_HZ(MCLK), .GUARD_CLKS(G), .FREQ_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .freq_hz(freq_hz), .wave_sel(wave_sel), .busy(busy), .err(err), .go(go),
        .good_to_reset_go(ack), .control(control), .adreg0(adreg0), .adreg1(adreg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tuning word = freq * 2^28 / MCLK, truncated or rounded to nearest.
    task automatic model(input logic [FW-1:0] f, input logic [1:0] w);
        longint unsigned num, q, r;
        logic [27:0] tw;
        num = longint'(f) << 28;
        q   = num / MCLK;
        r   = num % MCLK;
        if (RND && (2 * r >= MCLK)) q = (q >= 64'hFFFFFFF) ? 64'hFFFFFFF : q + 1;
        tw   = q[27:0];
        e_a0 = {2'b01, tw[13:0]};
        e_a1 = {2'b01, tw[27:14]};
        case (w)
            2'd1:    e_ctrl = 16'h2002;
            2'd2:    e_ctrl = 16'h2028;
            default: e_ctrl = 16'h2000;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_words(input string tag);
        check({tag, "_ctrl"}, control, e_ctrl);
        check({tag, "_a0"}, adreg0, e_a0);
        check({tag, "_a1"}, adreg1, e_a1);
    endtask

    task automatic accept(input string tag, input logic [FW-1:0] f, input logic [1:0] w);
        check({tag, "_ready"}, req_ready, 1);
        freq_hz = f; wave_sel = w; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (go !== 1'b1 && n < LAT + 20) begin tick(); n++; end
        check({tag, "_lat"}, n, LAT);
        check_words(tag);
    endtask

    task automatic wait_guard(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < G + 20) begin tick(); n++; end
        check({tag, "_guard"}, n, G);
    endtask

    task automatic ack_and_guard(input string tag, input int hold);
        int drop = 0;
        repeat (hold) begin tick(); if (go !== 1'b1) drop++; end
        if (hold > 0) check({tag, "_hold"}, drop, 0);
        ack = 1'b1;
        tick();
        check({tag, "_go_drop"}, go, 0);
        ack = 1'b0;
        wait_guard(tag);
    endtask

    task automatic good_txn(input string tag, input logic [FW-1:0] f, input logic [1:0] w);
        accept(tag, f, w);
        model(f, w);
        wait_go(tag);
        ack_and_guard(tag, 0);
    endtask

    task automatic bad_txn(input string tag, input logic [FW-1:0] f, input logic [1:0] w);
        accept(tag, f, w);
        check({tag, "_err"}, err, 1);
        tick();
        check({tag, "_err_end"}, err, 0);
        check({tag, "_ready_back"}, req_ready, 1);
        check({tag, "_nogo"}, go, 0);
        check_words(tag);
    endtask

    initial begin
        logic [FW-1:0] f;
        logic [1:0]    w;
        rst_n = 1'b0; req_valid = 1'b0; freq_hz = '0; wave_sel = '0; ack = 1'b0;
        repeat (3) tick();
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_go", go, 0);
        check_words("rst");
        rst_n = 1'b1;
        tick();

        // 1 MHz sine, with a long ack stall
        accept("sine1m", 24'd1000000, 2'd0);
        model(24'd1000000, 2'd0);
        wait_go("sine1m");
        check("sine1m_a0_tp", adreg0, 16'h570A);
        check("sine1m_a1_tp", adreg1, 16'h428F);
        ack_and_guard("sine1m", 1000);

        // 1 Hz triangle: smallest nonzero, shows truncation vs rounding
        good_txn("tri1", 24'd1, 2'd1);
        check("tri1_a0_tp", adreg0, RND ? 16'h400B : 16'h400A);

        // rejects leave words untouched
        bad_txn("rej_nyq", 24'd12500000, 2'd0);
        bad_txn("rej_wave", 24'd100, 2'd3);

        // largest legal frequency
        good_txn("max", 24'd12499999, 2'd2);

        // ack already high before ISSUE: go must still pulse exactly one cycle
        f = 24'($urandom_range(0, MCLK / 2 - 1));
        ack = 1'b1;
        accept("early", f, 2'd1);
        model(f, 2'd1);
        wait_go("early");
        tick();
        check("early_go_pulse", go, 0);
        ack = 1'b0;
        wait_guard("early");

        // randomized mix of legal and illegal requests
        for (int i = 0; i < 8; i++) begin
            w = 2'($urandom_range(0, 2));
            f = 24'($urandom_range(0, MCLK / 2 - 1));
            case ($urandom_range(0, 3))
                0:       bad_txn("rnd_badf", 24'($urandom_range(MCLK / 2, 24'hFFFFFF)), w);
                1:       bad_txn("rnd_badw", f, 2'd3);
                default: good_txn("rnd", f, w);
            endcase
        end

        // back-to-back with req_valid held: second waits out the guard
        freq_hz = 24'd5000; wave_sel = 2'd2; req_valid = 1'b1;
        tick();
        freq_hz = 24'd0; wave_sel = 2'd0;
        model(24'd5000, 2'd2);
        wait_go("b2b_a");
        ack_and_guard("b2b_a", 3);
        tick();
        req_valid = 1'b0;
        check("b2b_b_busy", busy, 1);
        model(24'd0, 2'd0);
        wait_go("b2b_b");
        check("b2b_b_ctrl_tp", control, 16'h2000);
        check("b2b_b_a0_tp", adreg0, 16'h4000);
        ack_and_guard("b2b_b", 0);

        // reset mid-DIVIDE
        good_txn("pre_rst", 24'd3000000, 2'd1);
        accept("rst_div", 24'd777777, 2'd2);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        e_ctrl = 16'h2100; e_a0 = 16'h4000; e_a1 = 16'h4000;
        check("rst_div_go", go, 0);
        check("rst_div_busy", busy, 0);
        check_words("rst_div");
        #2 rst_n = 1'b1;
        tick();
        check("rst_div_ready", req_ready, 1);

        // reset during ISSUE drops go without a clock edge
        accept("rst_iss", 24'd42000, 2'd0);
        model(24'd42000, 2'd0);
        wait_go("rst_iss");
        rst_n = 1'b0;
        #1;
        check("rst_iss_go", go, 0);
        #2 rst_n = 1'b1;
        e_ctrl = 16'h2100; e_a0 = 16'h4000; e_a1 = 16'h4000;
        tick();
        check_words("rst_iss");

        good_txn("recover", 24'($urandom_range(0, MCLK / 2 - 1)), 2'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
